// File: rtl/sync_fifo.sv
// Single-clock FIFO with binary wrap-around pointers, a separate occupancy
// counter, registered read data with a valid strobe, and one-cycle
// overflow/underflow pulses for rejected requests.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_acc;
    logic              wr_acc;
    logic [ADDR_W:0]   count_next;

    // Acceptance comes only from registered flags; a write into a full FIFO
    // is allowed when a read frees a slot in the same cycle, but an empty
    // FIFO never forwards a same-cycle write to the read side.
    always_comb begin
        rd_acc     = rd_en & ~empty;
        wr_acc     = wr_en & (~full | rd_acc);
        count_next = count + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    end

    // Storage is left uncleared by reset, but reset still blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy, flags, read data and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + ADDR_W'(1);
            end
            rd_valid  <= rd_acc;
            count     <= count_next;
            empty     <= (count_next == '0);
            full      <= (count_next == DEPTH_CNT);
            overflow  <= wr_en & ~wr_acc;
            underflow <= rd_en & ~rd_acc;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: the stimulus task pushes each expected read
// word into a scoreboard queue, and an independent monitor pops and compares
// whenever rd_valid is seen. Flags and counts are checked per vector.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int         nvec = 0;
    int         nmis = 0;
    logic [7:0] sb [$];

    sync_fifo #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        nvec++;
        if (actual != expected) begin
            nmis++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every presented read word must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (sb.size() == 0) begin
                check_output("rd_data_unexpected", 1, 0);
            end else begin
                check_output("rd_data", int'(rd_data), int'(sb.pop_front()));
            end
        end
    end

    // One cycle of stimulus with hand-computed expected post-edge state.
    task automatic apply_stimulus(input logic w, input logic [7:0] wd, input logic r,
                                  input logic exp_rd, input logic [7:0] exp_data,
                                  input int exp_count, input logic exp_ovf,
                                  input logic exp_unf);
        @(negedge clk);
        wr_en   = w;
        wr_data = wd;
        rd_en   = r;
        if (exp_rd) sb.push_back(exp_data);
        @(posedge clk);
        #1;
        check_output("count",     int'(count),     exp_count);
        check_output("full",      int'(full),      int'(exp_count == 4));
        check_output("empty",     int'(empty),     int'(exp_count == 0));
        check_output("rd_valid",  int'(rd_valid),  int'(exp_rd));
        check_output("overflow",  int'(overflow),  int'(exp_ovf));
        check_output("underflow", int'(underflow), int'(exp_unf));
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Two reset cycles with both requests asserted, then release.
    task automatic reset_check();
        @(negedge clk);
        rst     = 1'b1;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 8'hEE;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_empty",     int'(empty),     1);
        check_output("rst_full",      int'(full),      0);
        check_output("rst_count",     int'(count),     0);
        check_output("rst_rd_valid",  int'(rd_valid),  0);
        check_output("rst_overflow",  int'(overflow),  0);
        check_output("rst_underflow", int'(underflow), 0);
        check_output("rst_rd_data",   int'(rd_data),   0);
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        reset_check();

        // Fill and drain.
        apply_stimulus(1, 8'h11, 0, 0, 8'h00, 1, 0, 0);
        apply_stimulus(1, 8'h22, 0, 0, 8'h00, 2, 0, 0);
        apply_stimulus(1, 8'h33, 0, 0, 8'h00, 3, 0, 0);
        apply_stimulus(1, 8'h44, 0, 0, 8'h00, 4, 0, 0);
        apply_stimulus(0, 8'h00, 1, 1, 8'h11, 3, 0, 0);
        apply_stimulus(0, 8'h00, 1, 1, 8'h22, 2, 0, 0);
        apply_stimulus(0, 8'h00, 1, 1, 8'h33, 1, 0, 0);
        apply_stimulus(0, 8'h00, 1, 1, 8'h44, 0, 0, 0);

        // Overflow while full; the rejected word must never appear.
        apply_stimulus(1, 8'h11, 0, 0, 8'h00, 1, 0, 0);
        apply_stimulus(1, 8'h22, 0, 0, 8'h00, 2, 0, 0);
        apply_stimulus(1, 8'h33, 0, 0, 8'h00, 3, 0, 0);
        apply_stimulus(1, 8'h44, 0, 0, 8'h00, 4, 0, 0);
        apply_stimulus(1, 8'h55, 0, 0, 8'h00, 4, 1, 0);
        apply_stimulus(0, 8'h00, 1, 1, 8'h11, 3, 0, 0);
        apply_stimulus(0, 8'h00, 1, 1, 8'h22, 2, 0, 0);
        apply_stimulus(0, 8'h00, 1, 1, 8'h33, 1, 0, 0);
        apply_stimulus(0, 8'h00, 1, 1, 8'h44, 0, 0, 0);

        // Underflow with a simultaneous write: no bypass, write still lands.
        apply_stimulus(1, 8'hA5, 1, 0, 8'h00, 1, 0, 1);
        apply_stimulus(0, 8'h00, 1, 1, 8'hA5, 0, 0, 0);

        // Simultaneous read and write while full.
        apply_stimulus(1, 8'h11, 0, 0, 8'h00, 1, 0, 0);
        apply_stimulus(1, 8'h22, 0, 0, 8'h00, 2, 0, 0);
        apply_stimulus(1, 8'h33, 0, 0, 8'h00, 3, 0, 0);
        apply_stimulus(1, 8'h44, 0, 0, 8'h00, 4, 0, 0);
        apply_stimulus(1, 8'h99, 1, 1, 8'h11, 4, 0, 0);
        apply_stimulus(0, 8'h00, 1, 1, 8'h22, 3, 0, 0);
        apply_stimulus(0, 8'h00, 1, 1, 8'h33, 2, 0, 0);
        apply_stimulus(0, 8'h00, 1, 1, 8'h44, 1, 0, 0);
        apply_stimulus(0, 8'h00, 1, 1, 8'h99, 0, 0, 0);

        // Wrap-around with alternating single write/read pairs.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1, 8'(i), 0, 0, 8'h00, 1, 0, 0);
            apply_stimulus(0, 8'h00, 1, 1, 8'(i), 0, 0, 0);
        end

        // Mid-operation reset discards contents.
        apply_stimulus(1, 8'h77, 0, 0, 8'h00, 1, 0, 0);
        apply_stimulus(1, 8'h88, 0, 0, 8'h00, 2, 0, 0);
        reset_check();
        apply_stimulus(0, 8'h00, 1, 0, 8'h00, 0, 0, 1);
        apply_stimulus(1, 8'h66, 0, 0, 8'h00, 1, 0, 0);
        apply_stimulus(0, 8'h00, 1, 1, 8'h66, 0, 0, 0);

        // Let the monitor consume the last word, then confirm nothing is owed.
        repeat (2) @(negedge clk);
        check_output("scoreboard_left", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock FIFO buffer that consumes the wrap-around read/write pointer sequences of the FIFO_231026 counter stage, storing up to 2^ADDR_W words. Pointers are ADDR_W-bit binary counters that wrap modulo depth, matching the 2-bit counter at the default depth of 4. A separate occupancy counter drives the full/empty flags. Read data is registered, with a valid strobe.

Parameters:
DATA_W, 8, width of each stored word
ADDR_W, 2, pointer width; DEPTH = 2^ADDR_W (default 4)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
wr_en  input  1  write request
wr_data  input  DATA_W  write word
rd_en  input  1  read request
rd_data  output  DATA_W  registered read word
rd_valid  output  1  rd_data holds a newly read word this cycle
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset (rst=1 at a clk edge): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Storage array is not cleared. Reset overrides all requests in the same cycle. Mid-operation reset discards contents, and the next cycle behaves as after power-up.
- Acceptance, decided from registered state at the edge:
  - rd_acc = rd_en & ~empty
  - wr_acc = wr_en & (~full | rd_acc)
  - A write while full is accepted only when a read is accepted in the same cycle.
  - A read while empty is never accepted, even with a simultaneous write; no bypass path exists.
- Write: if wr_acc, mem[wr_ptr] <= wr_data and wr_ptr <= wr_ptr+1, wrapping mod DEPTH (DEPTH-1 -> 0).
- Read: if rd_acc, rd_data <= mem[rd_ptr], rd_ptr <= rd_ptr+1 (wrapping), rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds its last value.
- Read latency: the word appears on rd_data exactly one cycle after the accepting edge.
- Same-address hazard: a read and write to the same slot in one cycle occurs only when full; the read returns the old word.
- Occupancy update:
  - count <= count + wr_acc - rd_acc
  - full and empty are registered, derived from the next count, and valid in the same cycle as count.
- Error pulses:
  - overflow <= wr_en & ~wr_acc
  - underflow <= rd_en & ~rd_acc
  - Each pulse lasts one cycle per rejected request; FIFO state is unchanged by a rejected request.
- Invariants: count never exceeds DEPTH or goes below 0; full and empty are never both 1; (wr_ptr - rd_ptr) mod DEPTH == count mod DEPTH.

Test Plan:
- Reset check: assert rst for 2 cycles with wr_en=rd_en=1 -> empty=1, full=0, count=0, rd_valid=0, overflow=underflow=0.
- Fill and drain: write 0x11, 0x22, 0x33, 0x44 -> full=1, count=4. Then read 4 times -> rd_data 0x11, 0x22, 0x33, 0x44, each one cycle after its accepting edge with rd_valid=1; ends with empty=1.
- Overflow: when full, write 0x55 alone -> overflow pulses for 1 cycle, count stays 4; subsequent reads return 0x11..0x44 with 0x55 absent.
- Underflow: when empty, rd_en=1 together with wr_en=1, wr_data=0xA5 -> underflow pulses, rd_valid=0, count=1. Next cycle, a read returns 0xA5.
- Simultaneous read/write when full: full with 0x11..0x44, assert wr_en (0x99) and rd_en together -> rd_data=0x11, count stays 4, full stays 1. Draining then yields 0x22, 0x33, 0x44, 0x99.
- Wrap-around: perform 10 alternating single write/read pairs with wr_data = 0..9 -> each read returns the matching value, pointers wrap through 3 -> 0 at least twice, and count alternates 1/0.
